edge_level_generator: RTL

//   Rebuilds a level waveform from single-cycle rise/fall request pulses.

---
 rtl/edge_level_gen_pkg.sv | 27 ++
 rtl/edge_level_generator_hold_timer.sv | 32 +++
 rtl/edge_level_generator.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/edge_level_gen_pkg.sv
// Shared types for the edge/level generator: FSM state encoding and
// small state-classification helpers.
package edge_level_gen_pkg;

  localparam logic [1:0] ST_LOW_STABLE  = 2'd0;
  localparam logic [1:0] ST_HIGH_HOLD   = 2'd1;
  localparam logic [1:0] ST_HIGH_STABLE = 2'd2;
  localparam logic [1:0] ST_LOW_HOLD    = 2'd3;

  typedef enum logic [1:0] {
    LOW_STABLE  = ST_LOW_STABLE,
    HIGH_HOLD   = ST_HIGH_HOLD,
    HIGH_STABLE = ST_HIGH_STABLE,
    LOW_HOLD    = ST_LOW_HOLD
  } state_t;

  // Level currently driven in a given state.
  function automatic logic st_is_high(state_t s);
    return (s == HIGH_HOLD) || (s == HIGH_STABLE);
  endfunction

  // Hold states are the ones in which the minimum-stable timer may still run.
  function automatic logic st_is_hold(state_t s);
    return (s == HIGH_HOLD) || (s == LOW_HOLD);
  endfunction

endpackage

// File: rtl/edge_level_generator_hold_timer.sv
// edge_hold_timer: loadable down-counter that saturates at zero.
// Load has priority over decrement; zero_o flags an expired hold window.
module edge_hold_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: reload on a transition, otherwise count down to zero and stop.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                  cnt_d = load_val_i;
    else if (cnt_q != '0)        cnt_d = cnt_q - CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/edge_level_generator.sv
// edge_level_generator: rebuilds a level from rise/fall request pulses and
// keeps the level stable for MIN_HOLD cycles after every transition.
// Build option EDGE_LEVEL_GEN_PENDING_EN: an opposite request arriving
// during the hold window is remembered (1 deep) instead of dropped.
module edge_level_generator
  import edge_level_gen_pkg::*;
#(
  parameter int MIN_HOLD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rise_req_i,
  input  logic fall_req_i,
  output logic sig_out_o,
  output logic rise_done_o,
  output logic fall_done_o,
  output logic busy_o,
  output logic req_drop_o
);

  localparam int CNT_W = $clog2(MIN_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD - 1);

  if (MIN_HOLD < 1) begin : g_bad_hold
    $error("edge_level_generator: MIN_HOLD must be >= 1");
  end

  state_t state_q, state_d;
  logic   sig_q, sig_d;
  logic   rise_done_q, rise_done_d;
  logic   fall_done_q, fall_done_d;
  logic   drop_q, drop_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_cnt;
  logic             tmr_zero;

  logic conflict, up, dn, opp, same, ready, busy, take;

  edge_hold_timer #(.CNT_W(CNT_W)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .load_val_i(HOLD_LOAD),
    .cnt_o     (tmr_cnt),
    .zero_o    (tmr_zero)
  );

  // Request classification relative to the current level.
  always_comb begin
    conflict = rise_req_i && fall_req_i;
    up       = rise_req_i && !fall_req_i;
    dn       = fall_req_i && !rise_req_i;
    opp      = st_is_high(state_q) ? dn : up;
    same     = st_is_high(state_q) ? up : dn;
    busy     = st_is_hold(state_q) && (tmr_cnt != '0);
    ready    = !busy;
  end

`ifdef EDGE_LEVEL_GEN_PENDING_EN
  logic pend_q, pend_d;

  // Pending flag: set by an opposite request during hold, cancelled by a
  // same-direction request, consumed when the deferred transition fires.
  always_comb begin
    pend_d = pend_q;
    if (take)                         pend_d = 1'b0;
    else if (!conflict && same)       pend_d = 1'b0;
    else if (!conflict && busy && opp) pend_d = 1'b1;
  end

  // Pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= 1'b0;
    else        pend_q <= pend_d;
  end
`endif

  // Next state and registered-output values.
  always_comb begin
    state_d     = state_q;
    sig_d       = sig_q;
    rise_done_d = 1'b0;
    fall_done_d = 1'b0;
    drop_d      = 1'b0;
    tmr_load    = 1'b0;
    take        = 1'b0;

    if (conflict) drop_d = 1'b1;

    if (ready) begin
`ifdef EDGE_LEVEL_GEN_PENDING_EN
      // A same-direction request cancels a pending one at the deadline too.
      take = (!conflict && opp) || (pend_q && !(!conflict && same));
`else
      take = !conflict && opp;
`endif
    end
`ifndef EDGE_LEVEL_GEN_PENDING_EN
    else if (!conflict && opp) begin
      drop_d = 1'b1;
    end
`endif

    if (take) begin
      tmr_load = 1'b1;
      sig_d    = !sig_q;
      if (st_is_high(state_q)) begin
        state_d     = LOW_HOLD;
        fall_done_d = 1'b1;
      end else begin
        state_d     = HIGH_HOLD;
        rise_done_d = 1'b1;
      end
    end else if (st_is_hold(state_q) && tmr_zero) begin
      state_d = st_is_high(state_q) ? HIGH_STABLE : LOW_STABLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOW_STABLE;
      sig_q       <= 1'b0;
      rise_done_q <= 1'b0;
      fall_done_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_q       <= sig_d;
      rise_done_q <= rise_done_d;
      fall_done_q <= fall_done_d;
      drop_q      <= drop_d;
    end
  end

  assign sig_out_o   = sig_q;
  assign rise_done_o = rise_done_q;
  assign fall_done_o = fall_done_q;
  assign busy_o      = busy;
  assign req_drop_o  = drop_q;

endmodule
